// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXEC/UPDATE sequencer that owns the
// PC register's load/output enables and computes the next PC from the
// decoder's instruction class. Raises a one-cycle CP0 exception-entry strobe
// for syscall/break. No branch delay slot.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_in,
  output logic        pc_out,
  output logic [31:0] pc_next,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        halt,
  input  logic        is_branch,
  input  logic        br_taken,
  input  logic        is_j,
  input  logic        is_jr,
  input  logic        is_eret,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] rs_value,
  input  logic [31:0] epc_value,
  input  logic        ex_done,
  output logic        exc_req,
  output logic [4:0]  exc_cause,
  output logic [31:0] epc_save,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0] CAUSE_BREAK   = 5'd9;
  localparam logic [4:0] CAUSE_NONE    = 5'd0;

  state_t      state_q, state_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        exc_q, exc_d;
  logic [4:0]  cause_q, cause_d;

  // Decode-stage target selection; only sampled while in DECODE.
  logic [31:0] pc4_s;
  logic [31:0] br_tgt_s;
  logic [31:0] sel_tgt_s;
  logic        sel_exc_s;
  logic [4:0]  sel_cause_s;

  assign pc4_s    = pc_cur + 32'd4;
  assign br_tgt_s = pc4_s + {{14{br_offset[15]}}, br_offset, 2'b00};

  // Resolve the next-PC source by class priority (exceptions highest).
  always_comb begin
    sel_tgt_s   = pc4_s;
    sel_exc_s   = 1'b0;
    sel_cause_s = CAUSE_NONE;
    if (is_syscall) begin
      sel_tgt_s   = EXC_VECTOR;
      sel_exc_s   = 1'b1;
      sel_cause_s = CAUSE_SYSCALL;
    end else if (is_break) begin
      sel_tgt_s   = EXC_VECTOR;
      sel_exc_s   = 1'b1;
      sel_cause_s = CAUSE_BREAK;
    end else if (is_eret) begin
      sel_tgt_s = epc_value;
    end else if (is_jr) begin
      sel_tgt_s = rs_value;
    end else if (is_j) begin
      sel_tgt_s = {pc4_s[31:28], j_index, 2'b00};
    end else if (is_branch && br_taken) begin
      sel_tgt_s = br_tgt_s;
    end else begin
      sel_tgt_s = pc4_s;
    end
  end

  // Next-state and decode-capture logic for the instruction sequencer.
  always_comb begin
    state_d   = state_q;
    inst_pc_d = inst_pc_q;
    tgt_d     = tgt_q;
    exc_d     = exc_q;
    cause_d   = cause_q;
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack && !halt) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        inst_pc_d = pc_cur;
        tgt_d     = sel_tgt_s;
        exc_d     = sel_exc_s;
        cause_d   = sel_cause_s;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        // Exceptions bypass the execution unit entirely.
        if (exc_q || ex_done) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_UPDATE: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // Sequencer state and decode-captured registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      inst_pc_q <= RESET_PC;
      tgt_q     <= RESET_PC;
      exc_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      inst_pc_q <= inst_pc_d;
      tgt_q     <= tgt_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
    end
  end

  // Moore outputs decoded from registered state; the fetch handshake is
  // the only path that is combinational with inputs.
  assign state     = state_q;
  assign pc_out    = (state_q != S_RESET);
  assign pc_in     = (state_q == S_UPDATE);
  assign pc_next   = tgt_q;
  assign exc_req   = (state_q == S_UPDATE) && exc_q;
  assign exc_cause = exc_req ? cause_q : CAUSE_NONE;
  assign epc_save  = exc_req ? inst_pc_q : 32'd0;
  assign imem_req  = (state_q == S_FETCH) && !halt;
  assign ir_we     = imem_req && imem_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against a behavioural
// per-instruction reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        pc_in, pc_out, imem_req, imem_ack, ir_we, halt;
  logic [31:0] pc_next;
  logic        is_branch, br_taken, is_j, is_jr, is_eret, is_syscall, is_break;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] rs_value, epc_value;
  logic        ex_done, exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] epc_save;
  logic [2:0]  state;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_in(pc_in), .pc_out(pc_out),
    .pc_next(pc_next), .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .halt(halt), .is_branch(is_branch), .br_taken(br_taken), .is_j(is_j),
    .is_jr(is_jr), .is_eret(is_eret), .is_syscall(is_syscall), .is_break(is_break),
    .br_offset(br_offset), .j_index(j_index), .rs_value(rs_value),
    .epc_value(epc_value), .ex_done(ex_done), .exc_req(exc_req),
    .exc_cause(exc_cause), .epc_save(epc_save), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC: plain arithmetic on the class rules.
  function automatic logic [31:0] ref_target(
    input logic [31:0] pc, input logic sys, input logic brk, input logic eret,
    input logic jr, input logic j, input logic br, input logic tk,
    input logic [15:0] off, input logic [25:0] idx,
    input logic [31:0] rs, input logic [31:0] epc);
    logic [31:0] pc4;
    int          soff;
    logic [31:0] jt;
    pc4  = pc + 32'd4;
    soff = $signed(off);
    jt   = {4'd0, idx, 2'b00};
    if (sys || brk)    return EXC_VECTOR;
    else if (eret)     return epc;
    else if (jr)       return rs;
    else if (j)        return (pc4 & 32'hF000_0000) | jt;
    else if (br && tk) return pc4 + 32'(soff * 4);
    else               return pc4;
  endfunction

  // Drives one instruction from FETCH to the following FETCH and checks it.
  task automatic run_instr(
    input logic [31:0] pc, input logic sys, input logic brk, input logic eret,
    input logic jr, input logic j, input logic br, input logic tk,
    input logic [15:0] off, input logic [25:0] idx,
    input logic [31:0] rs, input logic [31:0] epc,
    input int ack_dly, input int done_dly);
    logic        exc;
    logic [31:0] exp_t;
    logic [4:0]  exp_cause;
    exc       = sys | brk;
    exp_t     = ref_target(pc, sys, brk, eret, jr, j, br, tk, off, idx, rs, epc);
    exp_cause = sys ? 5'd8 : (brk ? 5'd9 : 5'd0);
    pc_cur = pc; is_syscall = sys; is_break = brk; is_eret = eret; is_jr = jr;
    is_j = j; is_branch = br; br_taken = tk; br_offset = off; j_index = idx;
    rs_value = rs; epc_value = epc; halt = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      #1;
      chk("fetch_wait_state", {29'd0, state}, 32'd1);
      chk("fetch_wait_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_wait_irwe", {31'd0, ir_we}, 32'd0);
      tick();
    end
    imem_ack = 1'b1;
    #1;
    chk("fetch_state", {29'd0, state}, 32'd1);
    chk("fetch_irwe", {31'd0, ir_we}, 32'd1);
    chk("fetch_pcout", {31'd0, pc_out}, 32'd1);
    tick();
    imem_ack = 1'($urandom_range(0, 1));
    #1;
    chk("decode_state", {29'd0, state}, 32'd2);
    chk("decode_irwe", {31'd0, ir_we}, 32'd0);
    chk("decode_pcin", {31'd0, pc_in}, 32'd0);
    tick();
    imem_ack = 1'($urandom_range(0, 1));
    if (!exc) begin
      for (int i = 0; i < done_dly; i++) begin
        chk("exec_wait_state", {29'd0, state}, 32'd3);
        chk("exec_wait_pcin", {31'd0, pc_in}, 32'd0);
        tick();
      end
      ex_done = 1'b1;
    end
    chk("exec_state", {29'd0, state}, 32'd3);
    tick();
    ex_done = 1'b0;
    imem_ack = 1'b0;
    chk("update_state", {29'd0, state}, 32'd4);
    chk("update_pcin", {31'd0, pc_in}, 32'd1);
    chk("update_pcnext", pc_next, exp_t);
    chk("update_excreq", {31'd0, exc_req}, {31'd0, exc});
    chk("update_cause", {27'd0, exc_cause}, {27'd0, exp_cause});
    chk("update_epc", epc_save, exc ? pc : 32'd0);
    tick();
    chk("next_fetch_state", {29'd0, state}, 32'd1);
    chk("next_fetch_pcin", {31'd0, pc_in}, 32'd0);
    chk("next_fetch_excreq", {31'd0, exc_req}, 32'd0);
    model_pc = exp_t;
  endtask

  initial begin
    rst = 1'b1; pc_cur = RESET_PC; imem_ack = 1'b0; halt = 1'b0; ex_done = 1'b0;
    is_branch = 1'b0; br_taken = 1'b0; is_j = 1'b0; is_jr = 1'b0; is_eret = 1'b0;
    is_syscall = 1'b0; is_break = 1'b0; br_offset = 16'd0; j_index = 26'd0;
    rs_value = 32'd0; epc_value = 32'd0;
    tick(); tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pcout", {31'd0, pc_out}, 32'd0);
    chk("rst_pcin", {31'd0, pc_in}, 32'd0);
    chk("rst_imemreq", {31'd0, imem_req}, 32'd0);
    chk("rst_pcnext", pc_next, RESET_PC);
    chk("rst_excreq", {31'd0, exc_req}, 32'd0);
    chk("rst_cause", {27'd0, exc_cause}, 32'd0);
    chk("rst_epc", epc_save, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_state", {29'd0, state}, 32'd1);
    model_pc = RESET_PC;

    // Sequential stream.
    for (int k = 0; k < 3; k++)
      run_instr(model_pc, 0, 0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd0, 0, 0);
    chk("seq_third_pc", model_pc, 32'h0040_000C);

    // Branch taken / not taken, j, jr.
    run_instr(32'h0040_0010, 0, 0, 0, 0, 0, 1, 1, 16'hFFFE, 26'd0, 32'd0, 32'd0, 0, 0);
    run_instr(32'h0040_0010, 0, 0, 0, 0, 0, 1, 0, 16'hFFFE, 26'd0, 32'd0, 32'd0, 0, 0);
    run_instr(32'h0040_0020, 0, 0, 0, 0, 1, 0, 0, 16'd0, 26'h0100008, 32'd0, 32'd0, 0, 0);
    run_instr(32'h0040_0020, 0, 0, 0, 1, 0, 0, 0, 16'd0, 26'd0, 32'h0040_0100, 32'd0, 0, 0);

    // Exceptions, eret, and mixed class bits.
    run_instr(32'h0040_0040, 1, 0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd0, 0, 0);
    run_instr(32'h0040_0040, 1, 0, 1, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0, 32'h0040_0200, 0, 0);
    run_instr(32'h0040_0050, 0, 1, 0, 1, 1, 1, 1, 16'd4, 26'd5, 32'h1234_5678, 32'd0, 1, 0);
    run_instr(32'h0040_0060, 0, 0, 1, 1, 0, 0, 0, 16'd0, 26'd0, 32'h1111_1110, 32'h0040_0300, 0, 0);

    // Slow memory and slow execution.
    run_instr(model_pc, 0, 0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd0, 3, 5);

    // Halt in FETCH: no request, no ir latch, no progress.
    halt = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("halt_state", {29'd0, state}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_irwe", {31'd0, ir_we}, 32'd0);
      tick();
    end
    halt = 1'b0; imem_ack = 1'b0;

    // Reset asserted in EXEC.
    pc_cur = model_pc; imem_ack = 1'b1; ex_done = 1'b0;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("mid_exec_state", {29'd0, state}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", {29'd0, state}, 32'd0);
    chk("mid_rst_pcin", {31'd0, pc_in}, 32'd0);
    chk("mid_rst_pcnext", pc_next, RESET_PC);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_fetch", {29'd0, state}, 32'd1);
    run_instr(RESET_PC, 0, 0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd0, 0, 0);
    chk("after_rst_pc", model_pc, 32'h0040_0004);

    // PC wrap.
    run_instr(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0, 32'd0, 0, 0);
    chk("wrap_pc", model_pc, 32'h0000_0000);

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : model_pc;
      run_instr(pc,
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), 16'($urandom()), 26'($urandom()),
                $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
